// File: rtl/pc_sequencer.sv
// pc_sequencer: PC / hazard sequencer for a 5-stage pipeline.
// It chooses the next-PC source, drives the pipeline stalls and flushes,
// holds a redirect that is still waiting for its fetch to complete, and
// parks in a halted state until reset.
// Optional feature: define PC_PERF_CNT_EN to add saturating stall and flush
// counters (stall_cnt, flush_cnt). CNT_W is used only by that feature.
module pc_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dmem_req,
    input  logic             dhit,
    input  logic             halt_mem,
    input  logic             jump_id,
    input  logic             jr_ex,
    input  logic             branch_ex,
    input  logic             beq_ex,
    input  logic             zero_ex,
    input  logic             loaduse_id,
    output logic             pcenable,
    output logic [1:0]       pcsrc,
    output logic             branch,
    output logic             BEQ,
    output logic             zero_f,
    output logic             stall_if,
    output logic             stall_id,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             halt
`ifdef PC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {RUN, DWAIT, REDIR, HALTED} state_t;

    localparam logic [1:0] SRC_SEQ = 2'b00;
    localparam logic [1:0] SRC_BR  = 2'b01;
    localparam logic [1:0] SRC_J   = 2'b10;
    localparam logic [1:0] SRC_JR  = 2'b11;

    state_t     state_q, state_d;
    logic [1:0] lat_src_q;
    logic       lat_branch_q, lat_beq_q, lat_zero_q;
    logic       lat_load;
    logic       halt_q;

    logic       taken;
    logic       ex_redirect;
    logic       redirect;
    logic [1:0] redir_src;

    // Redirect resolution; an EX redirect squashes the jump sitting in ID.
    always_comb begin
        taken       = branch_ex & (beq_ex ? zero_ex : ~zero_ex);
        ex_redirect = jr_ex | taken;
        redirect    = ex_redirect | jump_id;
        if (jr_ex) begin
            redir_src = SRC_JR;
        end else if (taken) begin
            redir_src = SRC_BR;
        end else if (jump_id) begin
            redir_src = SRC_J;
        end else begin
            redir_src = SRC_SEQ;
        end
    end

    // Next state and all combinational pipeline controls.
    always_comb begin
        state_d    = state_q;
        lat_load   = 1'b0;
        pcenable   = 1'b0;
        pcsrc      = SRC_SEQ;
        branch     = branch_ex;
        BEQ        = beq_ex;
        zero_f     = zero_ex;
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        unique case (state_q)
            RUN: begin
                if (halt_mem) begin
                    state_d  = HALTED;
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                end else if (dmem_req & ~dhit) begin
                    // EX is frozen, so any redirect in EX is re-seen afterwards.
                    state_d  = DWAIT;
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                end else if (redirect) begin
                    if (ihit) begin
                        pcenable   = 1'b1;
                        pcsrc      = redir_src;
                        flush_ifid = 1'b1;
                        flush_idex = ex_redirect;
                    end else begin
                        lat_load = 1'b1;
                        state_d  = REDIR;
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                    end
                end else if (loaduse_id) begin
                    stall_if   = 1'b1;
                    flush_idex = 1'b1;
                end else begin
                    pcenable = ihit;
                    stall_if = ~ihit;
                end
            end
            DWAIT: begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                if (dhit) begin
                    state_d = RUN;
                end
            end
            REDIR: begin
                pcsrc    = lat_src_q;
                branch   = lat_branch_q;
                BEQ      = lat_beq_q;
                zero_f   = lat_zero_q;
                stall_id = 1'b1;
                pcenable = ihit;
                stall_if = ~ihit;
                if (ihit) begin
                    flush_ifid = 1'b1;
                    flush_idex = (lat_src_q != SRC_J);
                    state_d    = RUN;
                end
            end
            HALTED: begin
                stall_if = 1'b1;
                stall_id = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign halt = halt_q;

`ifdef PC_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

    // All sequential state: FSM, redirect latch, registered halt, counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= RUN;
            lat_src_q    <= SRC_SEQ;
            lat_branch_q <= 1'b0;
            lat_beq_q    <= 1'b0;
            lat_zero_q   <= 1'b0;
            halt_q       <= 1'b0;
`ifdef PC_PERF_CNT_EN
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            halt_q  <= (state_d == HALTED);
            if (lat_load) begin
                lat_src_q    <= redir_src;
                lat_branch_q <= branch_ex;
                lat_beq_q    <= beq_ex;
                lat_zero_q   <= zero_ex;
            end
`ifdef PC_PERF_CNT_EN
            if (!pcenable && (state_q != HALTED) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
            if (flush_ifid && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
            end
`endif
        end
    end

endmodule
